// File: rtl/ram_arb_sp.sv
// ram_arb_sp: single-port block RAM shared by NUM_CH requesters.
//
// A round-robin arbiter grants at most one channel per cycle. A granted write
// updates the enabled bytes at the clock edge. A granted read enters a
// registered read pipeline of READ_LAT (1 or 2) stages. The pipeline is fully
// pipelined and returns one response per cycle.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_valid    per-channel request valid
//   req_ready    per-channel accept, one-hot or zero, combinational
//   req_we       per-channel 1 = write, 0 = read
//   req_addr     channel i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_wdata    channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_be       channel i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8], ignored on reads
//   rsp_valid    one-cycle pulse per channel when rsp_rdata carries its read
//   rsp_rdata    shared read data; holds its last value between responses
//   clear_start  (RAM_CLEAR_EN only) starts zero-filling the whole RAM
//   clear_busy   (RAM_CLEAR_EN only) high while the zero-fill runs
//
// Optional feature macro: RAM_CLEAR_EN adds the clear FSM and its ports.
module ram_arb_sp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_CH        = 3,
    parameter int READ_LAT      = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  req_valid,
    output logic [NUM_CH-1:0]                  req_ready,
    input  logic [NUM_CH-1:0]                  req_we,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0]    req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       req_wdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]   req_be,
    output logic [NUM_CH-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata
`ifdef RAM_CLEAR_EN
    ,
    input  logic                               clear_start,
    output logic                               clear_busy
`endif
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];
    logic [CH_W-1:0]          r_last;
    logic [CH_W-1:0]          w_sel;
    logic [CH_W-1:0]          w_cand;
    logic                     w_found;
    logic                     w_busy;
    logic [NUM_CH-1:0]        w_grant;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [NB-1:0]            w_be;
    logic                     w_we;
    logic                     w_rd_acc;
    logic                     w_mem_we;
    logic [ADDRESS_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]    w_mem_wdata;
    logic [NB-1:0]            w_mem_be;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(r_last) + k) % NUM_CH);
            if (!w_found && !w_busy && req_valid[w_cand]) begin
                w_found         = 1'b1;
                w_sel           = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    assign req_ready = w_grant;

    // Route the granted channel's request fields.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_we    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) begin
                w_addr  = req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_wdata = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
                w_be    = req_be[c*NB +: NB];
                w_we    = req_we[c];
            end
        end
    end

    assign w_rd_acc = w_found && !w_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CH_W'(NUM_CH - 1);
        end else if (w_found) begin
            r_last <= w_sel;
        end
    end

`ifdef RAM_CLEAR_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
                    if (&r_clr_addr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_busy     = (r_state == S_CLEAR);
    assign clear_busy = w_busy;

    // The clear owns the RAM port while busy; the arbiter grants nothing then.
    always_comb begin
        if (w_busy) begin
            w_mem_we    = !rst;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end else begin
            w_mem_we    = w_found && w_we && !rst;
            w_mem_addr  = w_addr;
            w_mem_wdata = w_wdata;
            w_mem_be    = w_be;
        end
    end
`else
    assign w_busy      = 1'b0;
    assign w_mem_we    = w_found && w_we && !rst;
    assign w_mem_addr  = w_addr;
    assign w_mem_wdata = w_wdata;
    assign w_mem_be    = w_be;
`endif

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage p0: RAM read register.
    logic [NUM_CH-1:0]     r_vld_p0;
    logic [DATA_WIDTH-1:0] r_rdata_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0   <= '0;
            r_rdata_p0 <= '0;
        end else begin
            r_vld_p0 <= w_rd_acc ? w_grant : '0;
            if (w_rd_acc) begin
                r_rdata_p0 <= r_mem[w_addr];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            // Stage p1: output register; loads only on a response so data holds.
            logic [NUM_CH-1:0]     r_vld_p1;
            logic [DATA_WIDTH-1:0] r_rdata_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p1   <= '0;
                    r_rdata_p1 <= '0;
                end else begin
                    r_vld_p1 <= r_vld_p0;
                    if (|r_vld_p0) begin
                        r_rdata_p1 <= r_rdata_p0;
                    end
                end
            end

            assign rsp_valid = r_vld_p1;
            assign rsp_rdata = r_rdata_p1;
        end else begin : g_lat1
            assign rsp_valid = r_vld_p0;
            assign rsp_rdata = r_rdata_p0;
        end
    endgenerate

endmodule

// File: tb/tb_ram_arb_sp.sv
`timescale 1ns/1ps
module tb_ram_arb_sp;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int NCH = 3;
    localparam int AW1 = 12;
    localparam int AW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NCH-1:0]      req_valid;
    logic [NCH-1:0]      req_we;
    logic [NCH*AW1-1:0]  req_addr;
    logic [NCH*AW2-1:0]  req_addr2;
    logic [NCH*DW-1:0]   req_wdata;
    logic [NCH*NB-1:0]   req_be;
    logic                clr_start2;
    logic [NCH-1:0]      rdy1, rdy2, rv1, rv2;
    logic [DW-1:0]       rd1, rd2;
    logic                busy1, busy2;

    // Second instance sees the low address bits of the same requests.
    for (genvar c = 0; c < NCH; c++) begin : g_addr2
        assign req_addr2[c*AW2 +: AW2] = req_addr[c*AW1 +: AW2];
    end

    ram_arb_sp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW1), .NUM_CH(NCH), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv1), .rsp_rdata(rd1)
`ifdef RAM_CLEAR_EN
        , .clear_start(1'b0), .clear_busy(busy1)
`endif
    );

    ram_arb_sp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW2), .NUM_CH(NCH), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr2), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv2), .rsp_rdata(rd2)
`ifdef RAM_CLEAR_EN
        , .clear_start(clr_start2), .clear_busy(busy2)
`endif
    );

`ifndef RAM_CLEAR_EN
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: memory contents with per-byte "known" flags, last granted
    // channel, remaining clear words, and responses scheduled by edge number.
    logic [DW-1:0]  m_mem   [2][4096];
    logic [NB-1:0]  m_known [2][4096];
    int             m_last  [2];
    int             m_clr_left [2];
    logic           s_v  [2][8];
    int             s_ch [2][8];
    logic [DW-1:0]  s_d  [2][8];
    logic [NB-1:0]  s_k  [2][8];
    logic [NCH-1:0] m_rv [2];
    logic [DW-1:0]  m_rd [2];
    logic [NB-1:0]  m_rk [2];

    function automatic int rr_pick(int last, logic [NCH-1:0] v, bit busy);
        if (busy) return -1;
        for (int k = 1; k <= NCH; k++) begin
            if (v[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] bmask(logic [NB-1:0] k);
        logic [DW-1:0] m;
        for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic model_edge();
        int dep, lat, g, a, slot;
        for (int d = 0; d < 2; d++) begin
            dep = (d == 0) ? 4096 : 16;
            lat = (d == 0) ? 1 : 2;
            if (rst) begin
                m_last[d]     = NCH - 1;
                m_clr_left[d] = 0;
                for (int s = 0; s < 8; s++) s_v[d][s] = 1'b0;
                m_rv[d] = '0;
                m_rd[d] = '0;
                m_rk[d] = '1;
            end else begin
                g = rr_pick(m_last[d], req_valid, m_clr_left[d] > 0);
                if (m_clr_left[d] > 0) begin
                    a = dep - m_clr_left[d];
                    m_mem[d][a]   = '0;
                    m_known[d][a] = '1;
                    m_clr_left[d]--;
                end else if (d == 1 && clr_start2) begin
                    m_clr_left[d] = dep;
                end
                if (g >= 0) begin
                    m_last[d] = g;
                    a = int'(req_addr[g*AW1 +: AW1]) % dep;
                    if (req_we[g]) begin
                        for (int b = 0; b < NB; b++) begin
                            if (req_be[g*NB + b]) begin
                                m_mem[d][a][b*8 +: 8] = req_wdata[g*DW + b*8 +: 8];
                                m_known[d][a][b] = 1'b1;
                            end
                        end
                    end else begin
                        slot = (cyc + lat - 1) % 8;
                        s_v[d][slot]  = 1'b1;
                        s_ch[d][slot] = g;
                        s_d[d][slot]  = m_mem[d][a];
                        s_k[d][slot]  = m_known[d][a];
                    end
                end
                slot = cyc % 8;
                m_rv[d] = '0;
                if (s_v[d][slot]) begin
                    m_rv[d][s_ch[d][slot]] = 1'b1;
                    m_rd[d] = s_d[d][slot];
                    m_rk[d] = s_k[d][slot];
                    s_v[d][slot] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_check();
        logic [NCH-1:0] e;
        logic [DW-1:0]  m;
        int g;
        for (int d = 0; d < 2; d++) begin
            g = rr_pick(m_last[d], req_valid, m_clr_left[d] > 0);
            e = '0;
            if (g >= 0) e[g] = 1'b1;
            m = bmask(m_rk[d]);
            check($sformatf("model dut%0d req_ready", d + 1), 64'(d == 0 ? rdy1 : rdy2), 64'(e));
            check($sformatf("model dut%0d rsp_valid", d + 1), 64'(d == 0 ? rv1 : rv2), 64'(m_rv[d]));
            check($sformatf("model dut%0d rsp_rdata", d + 1), 64'((d == 0 ? rd1 : rd2) & m), 64'(m_rd[d] & m));
        end
`ifdef RAM_CLEAR_EN
        check("model dut2 clear_busy", 64'(busy2), 64'(m_clr_left[1] > 0));
        check("model dut1 clear_busy", 64'(busy1), 64'(0));
`endif
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic r, logic [NCH-1:0] v, logic [NCH-1:0] we,
                         logic [AW1-1:0] a, logic [DW-1:0] wd, logic [NB-1:0] be);
        rst = r;
        req_valid = v;
        req_we = we;
        for (int c = 0; c < NCH; c++) begin
            req_addr[c*AW1 +: AW1] = a;
            req_wdata[c*DW +: DW]  = wd;
            req_be[c*NB +: NB]     = be;
        end
    endtask

    typedef struct {
        logic           r;
        logic [NCH-1:0] v;
        logic [NCH-1:0] we;
        logic [AW1-1:0] a;
        logic [DW-1:0]  wd;
        logic [NB-1:0]  be;
        logic [NCH-1:0] e_rdy;
        logic [NCH-1:0] e_rv;
        logic [DW-1:0]  e_rd;
    } vec_t;

    function automatic vec_t mk(logic r, logic [NCH-1:0] v, logic [NCH-1:0] we, logic [AW1-1:0] a,
                                logic [DW-1:0] wd, logic [NB-1:0] be,
                                logic [NCH-1:0] e_rdy, logic [NCH-1:0] e_rv, logic [DW-1:0] e_rd);
        vec_t t;
        t.r = r; t.v = v; t.we = we; t.a = a; t.wd = wd; t.be = be;
        t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rd = e_rd;
        return t;
    endfunction

    vec_t tbl [21];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4096; i++) m_known[d][i] = '0;
            for (int s = 0; s < 8; s++) s_v[d][s] = 1'b0;
        end
        clr_start2 = 1'b0;

        //            rst v      we     addr    wdata         be       rdy    rv     rdata
        tbl[0]  = mk(0, 3'b001, 3'b001, 12'h010, 32'hDEADBEEF, 4'hF, 3'b001, 3'b000, 32'h0);
        tbl[1]  = mk(0, 3'b001, 3'b000, 12'h010, 32'h0,        4'h0, 3'b001, 3'b000, 32'h0);
        tbl[2]  = mk(0, 3'b000, 3'b000, 12'h010, 32'h0,        4'h0, 3'b000, 3'b001, 32'hDEADBEEF);
        tbl[3]  = mk(0, 3'b001, 3'b001, 12'h020, 32'hDEADBEEF, 4'hF, 3'b001, 3'b000, 32'hDEADBEEF);
        tbl[4]  = mk(0, 3'b001, 3'b001, 12'h020, 32'h11223344, 4'h5, 3'b001, 3'b000, 32'hDEADBEEF);
        tbl[5]  = mk(0, 3'b001, 3'b000, 12'h020, 32'h0,        4'h0, 3'b001, 3'b000, 32'hDEADBEEF);
        tbl[6]  = mk(0, 3'b000, 3'b000, 12'h020, 32'h0,        4'h0, 3'b000, 3'b001, 32'hDE22BE44);
        tbl[7]  = mk(0, 3'b001, 3'b001, 12'h020, 32'hFFFFFFFF, 4'h0, 3'b001, 3'b000, 32'hDE22BE44);
        tbl[8]  = mk(0, 3'b001, 3'b000, 12'h020, 32'h0,        4'h0, 3'b001, 3'b000, 32'hDE22BE44);
        tbl[9]  = mk(0, 3'b000, 3'b000, 12'h020, 32'h0,        4'h0, 3'b000, 3'b001, 32'hDE22BE44);
        tbl[10] = mk(1, 3'b000, 3'b000, 12'h010, 32'h0,        4'h0, 3'b000, 3'b000, 32'hDE22BE44);
        tbl[11] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b001, 3'b000, 32'h0);
        tbl[12] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b010, 3'b001, 32'hDEADBEEF);
        tbl[13] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b100, 3'b010, 32'hDEADBEEF);
        tbl[14] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b001, 3'b100, 32'hDEADBEEF);
        tbl[15] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b010, 3'b001, 32'hDEADBEEF);
        tbl[16] = mk(0, 3'b111, 3'b000, 12'h010, 32'h0,        4'h0, 3'b100, 3'b010, 32'hDEADBEEF);
        tbl[17] = mk(0, 3'b000, 3'b000, 12'h010, 32'h0,        4'h0, 3'b000, 3'b100, 32'hDEADBEEF);
        tbl[18] = mk(0, 3'b101, 3'b000, 12'h010, 32'h0,        4'h0, 3'b001, 3'b000, 32'hDEADBEEF);
        tbl[19] = mk(0, 3'b101, 3'b000, 12'h010, 32'h0,        4'h0, 3'b100, 3'b001, 32'hDEADBEEF);
        tbl[20] = mk(0, 3'b000, 3'b000, 12'h010, 32'h0,        4'h0, 3'b000, 3'b100, 32'hDEADBEEF);

        // Initial reset.
        drive(1'b1, '0, '0, '0, '0, '0);
        #1;
        repeat (3) advance();
        drive(1'b0, '0, '0, '0, '0, '0);
        settle();
        check("reset dut1 req_ready", 64'(rdy1), 64'(0));
        check("reset dut1 rsp_valid", 64'(rv1), 64'(0));
        check("reset dut1 rsp_rdata", 64'(rd1), 64'(0));
        check("reset dut2 rsp_valid", 64'(rv2), 64'(0));
        check("reset dut2 rsp_rdata", 64'(rd2), 64'(0));
        advance();

        // Directed vectors on the READ_LAT=1 instance.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].be);
            settle();
            check($sformatf("tbl%0d req_ready", i), 64'(rdy1), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d rsp_valid", i), 64'(rv1), 64'(tbl[i].e_rv));
            check($sformatf("tbl%0d rsp_rdata", i), 64'(rd1), 64'(tbl[i].e_rd));
            advance();
        end

        // Back-to-back reads: preload 1..4 with A1..A4, then read them in a row.
        for (int w = 0; w < 4; w++) begin
            drive(1'b0, 3'b001, 3'b001, AW1'(w + 1), DW'(32'hA1 + w), 4'hF);
            settle();
            advance();
        end
        for (int j = 0; j < 7; j++) begin
            if (j < 4) drive(1'b0, 3'b001, 3'b000, AW1'(j + 1), '0, '0);
            else       drive(1'b0, 3'b000, 3'b000, '0, '0, '0);
            settle();
            check($sformatf("b2b%0d lat1 rsp_valid", j), 64'(rv1), 64'((j >= 1 && j <= 4) ? 3'b001 : 3'b000));
            check($sformatf("b2b%0d lat2 rsp_valid", j), 64'(rv2), 64'((j >= 2 && j <= 5) ? 3'b001 : 3'b000));
            if (j >= 1 && j <= 4) check($sformatf("b2b%0d lat1 rsp_rdata", j), 64'(rd1), 64'(32'hA1 + j - 1));
            if (j >= 2 && j <= 5) check($sformatf("b2b%0d lat2 rsp_rdata", j), 64'(rd2), 64'(32'hA1 + j - 2));
            advance();
        end

        // Reset while reads are in flight.
        drive(1'b0, 3'b001, 3'b000, 12'd1, '0, '0); settle(); advance();
        drive(1'b0, 3'b001, 3'b000, 12'd2, '0, '0); settle(); advance();
        drive(1'b1, 3'b001, 3'b000, 12'd3, '0, '0); settle(); advance();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 3'b000, 3'b000, '0, '0, '0);
            settle();
            check($sformatf("rstfl%0d dut1 rsp_valid", j), 64'(rv1), 64'(0));
            check($sformatf("rstfl%0d dut2 rsp_valid", j), 64'(rv2), 64'(0));
            check($sformatf("rstfl%0d dut1 rsp_rdata", j), 64'(rd1), 64'(0));
            check($sformatf("rstfl%0d dut2 rsp_rdata", j), 64'(rd2), 64'(0));
            advance();
        end
        drive(1'b0, 3'b111, 3'b000, 12'd1, '0, '0);
        settle();
        check("post-reset dut1 first grant", 64'(rdy1), 64'(3'b001));
        check("post-reset dut2 first grant", 64'(rdy2), 64'(3'b001));
        advance();
        drive(1'b0, 3'b000, 3'b000, '0, '0, '0);
        settle();
        advance();

`ifdef RAM_CLEAR_EN
        // Clear on the 16-word instance; a second start while busy is ignored.
        for (int j = 0; j < 18; j++) begin
            drive(1'b0, (j >= 1 && j <= 16) ? 3'b111 : 3'b000, 3'b000, 12'd5, '0, '0);
            clr_start2 = (j == 0 || j == 5);
            settle();
            check($sformatf("clr%0d clear_busy", j), 64'(busy2), 64'(j >= 1 && j <= 16));
            if (j >= 1 && j <= 16) check($sformatf("clr%0d req_ready", j), 64'(rdy2), 64'(0));
            advance();
        end
        clr_start2 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) drive(1'b0, 3'b001, 3'b000, AW1'(k), '0, '0);
            else        drive(1'b0, 3'b000, 3'b000, '0, '0, '0);
            settle();
            if (k >= 2) begin
                check($sformatf("clrrd%0d rsp_valid", k - 2), 64'(rv2), 64'(3'b001));
                check($sformatf("clrrd%0d rsp_rdata", k - 2), 64'(rd2), 64'(0));
            end
            advance();
        end
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = NCH'($urandom);
            req_we    = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                req_addr[c*AW1 +: AW1] = ($urandom_range(0, 3) == 0) ? AW1'($urandom) : AW1'($urandom_range(0, 15));
                req_wdata[c*DW +: DW]  = $urandom;
                req_be[c*NB +: NB]     = NB'($urandom);
            end
`ifdef RAM_CLEAR_EN
            clr_start2 = ($urandom_range(0, 79) == 0);
`endif
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arb_sp.md
Name: ram_arb_sp

Overview:
- Parametrised single-port block RAM shared by NUM_CH requesters through a round-robin arbiter with a valid/ready handshake.
- Supports byte-enabled writes and a 1- or 2-cycle registered read pipeline.
- Successor to the generic tri-state RAM. Used as the shared coefficient/pixel buffer between the Huffman, IDCT and colour-conversion stages of the decoder.
- All buses are flattened and unidirectional; there are no tri-states.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8.
- ADDRESS_WIDTH, 12: depth is 2**ADDRESS_WIDTH words.
- NUM_CH, 3: number of requester channels, 1..8.
- READ_LAT, 1: cycles from read acceptance to rsp_valid. Legal values are 1 and 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel accept; combinational from arbiter
- req_we  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDRESS_WIDTH  channel i at bits [i*AW +: AW]
- req_wdata  in  NUM_CH*DATA_WIDTH  channel i at bits [i*DW +: DW]
- req_be  in  NUM_CH*DATA_WIDTH/8  byte enables; ignored on reads
- rsp_valid  out  NUM_CH  one-cycle pulse: read data for channel i is valid
- rsp_rdata  out  DATA_WIDTH  read data, shared by all channels
- clear_start  in  1  present only with RAM_CLEAR_EN
- clear_busy  out  1  present only with RAM_CLEAR_EN

Behaviour:
- A request is accepted in a cycle when req_valid[i] && req_ready[i].
  - At most one channel is accepted per cycle.
  - req_ready is one-hot or zero.
  - req_ready[i] may assert only when req_valid[i] is high.
- Arbitration is round-robin.
  - Priority search starts at (last_grant+1) mod NUM_CH and wraps.
  - last_grant updates only on acceptance.
  - Reset value of last_grant is NUM_CH-1, so channel 0 has first priority.
- Write accept: each byte b with req_be[b]=1 is written at the rising edge. Bytes with req_be[b]=0 keep their old value. be=0 is a legal no-op.
- Read accept: the word at addr is registered.
  - READ_LAT=1: rsp_valid[i] and rsp_rdata appear the cycle after acceptance.
  - READ_LAT=2: an extra output register is added; data appears 2 cycles after acceptance.
  - Fully pipelined: back-to-back reads sustain one response per cycle.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. There is no same-cycle hazard because the RAM is single-port.
- No backpressure on responses; requesters must always sink rsp_valid.
- rsp_rdata holds its last value when rsp_valid is 0.
- Reset values:
  - rsp_valid = 0
  - rsp_rdata = 0
  - req_ready follows arbitration combinationally; 0 when no req_valid is asserted
  - Pipeline valid bits are cleared.
  - Memory contents are not reset.
- Reset mid-operation: in-flight reads are dropped with no rsp_valid. A write accepted in the reset cycle is not performed.
- Address is unsigned and never wraps; all 2**ADDRESS_WIDTH entries are usable.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Enabled: adds clear_start/clear_busy and a 2-state FSM (IDLE, CLEAR).
  - IDLE -> CLEAR on clear_start. clear_busy goes high the next cycle.
  - In CLEAR, a counter writes 0 to addresses 0 .. 2**ADDRESS_WIDTH-1, one per cycle, with full byte enable.
  - After the last address the FSM returns to IDLE and clear_busy drops. Total busy time is 2**ADDRESS_WIDTH cycles.
  - While busy, req_ready = 0 for all channels.
  - Reads already in the read pipeline still complete.
  - clear_start while busy is ignored.
  - rst aborts the clear and returns to IDLE with clear_busy=0.
- Disabled: the ports, FSM and counter are absent, and the RAM is never auto-cleared.

Test Plan:
- NUM_CH=3, READ_LAT=1. Ch0 writes 0xDEADBEEF to addr 0x010 with be=4'hF, then ch0 reads 0x010 -> the cycle after read acceptance: rsp_valid=3'b001, rsp_rdata=0xDEADBEEF.
- Byte enable: write 0xDEADBEEF to 0x020, then write 0x11223344 with be=4'b0101, then read 0x020 -> 0xDE22BE44.
- Fairness: all 3 channels hold continuous reads -> grants cycle 0,1,2,0,1,2. No channel is starved. Exactly one bit of req_ready is high per cycle.
- READ_LAT=2, back-to-back reads of addresses 1..4 preloaded with values 0xA1..0xA4 -> rsp_valid on 4 consecutive cycles starting 2 cycles after the first accept, with data 0xA1..0xA4 in order.
- Assert rst for 1 cycle while 2 reads are in flight -> no rsp_valid pulses afterwards; rsp_rdata=0. After reset, ch0 is granted first under contention.
- RAM_CLEAR_EN, ADDRESS_WIDTH=4: pulse clear_start -> clear_busy high for exactly 16 cycles with req_ready=0. Afterwards, reads of addresses 0..15 all return 0.
